// File: rtl/ram_burst_if.sv
// Command, RAM-port and read-stream bundle for ram_burst_ctrl.
// The master side is the burst controller. The slave side is the sequencer, RAM and consumer.
interface ram_burst_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W:0]   cmd_len;
  logic [DATA_W-1:0] cmd_seed;

  logic              ram_en;
  logic              ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;

  logic              done;
  logic              err;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len, cmd_seed, ram_dout, rd_ready,
    output cmd_ready, ram_en, ram_wr, ram_addr, ram_din, rd_valid, rd_data, rd_last, done, err
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len, cmd_seed, ram_dout, rd_ready,
    input  cmd_ready, ram_en, ram_wr, ram_addr, ram_din, rd_valid, rd_data, rd_last, done, err
  );
endinterface

// File: rtl/ram_burst_ctrl.sv
// Burst initiator for one RAM port. It performs incrementing-pattern fill and readback streaming.
// Optional readback checker: define RAM_BURST_CHECK_EN.
module ram_burst_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  ram_burst_if.master bus
);

  typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_HOLD} state_t;

  state_t            state;
  logic              cmdReady;
  logic              ramEn;
  logic              ramWr;
  logic [ADDR_W-1:0] ramAddr;
  logic [DATA_W-1:0] ramDin;
  logic              rdValid;
  logic [DATA_W-1:0] rdData;
  logic              rdLast;
  logic              doneR;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   lastIdx;
  logic              accept;

  assign accept = (state == IDLE) && bus.cmd_valid && cmdReady;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cmdReady <= '0;
      ramEn    <= '0;
      ramWr    <= '0;
      ramAddr  <= '0;
      ramDin   <= '0;
      rdValid  <= '0;
      rdData   <= '0;
      rdLast   <= '0;
      doneR    <= '0;
      idx      <= '0;
      lastIdx  <= '0;
    end else begin
      doneR <= 1'b0;
      unique case (state)
        IDLE: begin
          cmdReady <= 1'b1;
          if (accept) begin
            idx     <= '0;
            lastIdx <= bus.cmd_len - 1'b1;
            if (bus.cmd_len == '0) begin
              doneR <= 1'b1;
            end else begin
              cmdReady <= 1'b0;
              ramEn    <= 1'b1;
              ramAddr  <= bus.cmd_addr;
              if (bus.cmd_wr) begin
                state  <= WRITE;
                ramWr  <= 1'b1;
                ramDin <= bus.cmd_seed;
              end else begin
                state  <= RD_ISSUE;
              end
            end
          end
        end
        WRITE: begin
          if (idx == lastIdx) begin
            state    <= IDLE;
            ramEn    <= 1'b0;
            ramWr    <= 1'b0;
            cmdReady <= 1'b1;
            doneR    <= 1'b1;
          end else begin
            idx     <= idx + 1'b1;
            ramAddr <= ramAddr + 1'b1;
            ramDin  <= ramDin + 1'b1;
          end
        end
        RD_ISSUE: begin
          state <= RD_WAIT;
          ramEn <= 1'b0;
        end
        RD_WAIT: begin
          rdData  <= bus.ram_dout;
          rdValid <= 1'b1;
          rdLast  <= (idx == lastIdx);
          state   <= RD_HOLD;
        end
        RD_HOLD: begin
          if (bus.rd_ready) begin
            rdValid <= 1'b0;
            rdLast  <= 1'b0;
            if (idx == lastIdx) begin
              state    <= IDLE;
              cmdReady <= 1'b1;
              doneR    <= 1'b1;
            end else begin
              idx     <= idx + 1'b1;
              ramAddr <= ramAddr + 1'b1;
              ramEn   <= 1'b1;
              state   <= RD_ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmdReady;
  assign bus.ram_en    = ramEn;
  assign bus.ram_wr    = ramWr;
  assign bus.ram_addr  = ramAddr;
  assign bus.ram_din   = ramDin;
  assign bus.rd_valid  = rdValid;
  assign bus.rd_data   = rdData;
  assign bus.rd_last   = rdLast;
  assign bus.done      = doneR;

`ifdef RAM_BURST_CHECK_EN
  logic [DATA_W-1:0] expWord;
  logic              errR;

  // The expected word tracks seed+i. It advances on the same handshake that advances idx.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expWord <= '0;
      errR    <= '0;
    end else begin
      if (accept) begin
        expWord <= bus.cmd_seed;
        errR    <= 1'b0;
      end else begin
        if (state == RD_WAIT && bus.ram_dout != expWord) errR <= 1'b1;
        if (state == RD_HOLD && bus.rd_ready) expWord <= expWord + 1'b1;
      end
    end
  end

  assign bus.err = errR;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Randomized bench for ram_burst_ctrl. It checks against a memory-image reference model.
module tb_ram_burst_ctrl;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef RAM_BURST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ram_burst_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  ram_burst_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Synchronous-read RAM that the controller drives
  logic [DATA_W-1:0] ramMem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_wr) ramMem[bus.ram_addr] <= bus.ram_din;
      else            bus.ram_dout <= ramMem[bus.ram_addr];
    end
  end

  int refMem [DEPTH];
  bit errExp;
  int tests = 0;
  int fails = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic garbage();
    bus.cmd_valid = 1'($urandom_range(0, 1));
    bus.cmd_wr    = 1'($urandom_range(0, 1));
    bus.cmd_addr  = ADDR_W'($urandom);
    bus.cmd_len   = (ADDR_W+1)'($urandom);
    bus.cmd_seed  = DATA_W'($urandom);
    bus.rd_ready  = 1'($urandom_range(0, 1));
  endtask

  task automatic waitReady();
    int n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) checkVal("cmd_ready_timeout", 32'(bus.cmd_ready), 1);
  endtask

  task automatic issue(input bit wr, input int addr, input int len, input int seed);
    waitReady();
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = wr;
    bus.cmd_addr  = ADDR_W'(addr);
    bus.cmd_len   = (ADDR_W+1)'(len);
    bus.cmd_seed  = DATA_W'(seed);
    @(negedge clk);
    errExp = 1'b0;
    if (len == 0) bus.cmd_valid = 1'b0;
    else          garbage();
  endtask

  task automatic doWrite(input int addr, input int len, input int seed);
    issue(1'b1, addr, len, seed);
    for (int j = 0; j < len; j++) begin
      checkVal("wr_en",   32'({bus.ram_en, bus.ram_wr}), 2'b11);
      checkVal("wr_addr", 32'(bus.ram_addr), (addr + j) % DEPTH);
      checkVal("wr_din",  32'(bus.ram_din), (seed + j) % 256);
      checkVal("wr_busy", 32'({bus.cmd_ready, bus.done}), 0);
      refMem[(addr + j) % DEPTH] = (seed + j) % 256;
      @(negedge clk);
      garbage();
    end
    bus.cmd_valid = 1'b0;
    checkVal("wr_done", 32'({bus.done, bus.ram_en, bus.cmd_ready}), 3'b101);
    checkVal("wr_err",  32'(bus.err), 32'(errExp));
  endtask

  // stallWord >= 0: hold rd_ready low stallLen cycles on that word; -1: random stalls; else none
  task automatic doRead(input int addr, input int len, input int seed,
                        input int stallWord, input int stallLen);
    int cyc = 0;
    int stalls = 0;
    int ns;
    int exp;
    issue(1'b0, addr, len, seed);
    for (int i = 0; i < len; i++) begin
      checkVal("rd_issue", 32'({bus.ram_en, bus.ram_wr, bus.rd_valid}), 3'b100);
      checkVal("rd_addr",  32'(bus.ram_addr), (addr + i) % DEPTH);
      @(negedge clk); garbage(); cyc++;
      checkVal("rd_wait", 32'({bus.ram_en, bus.rd_valid}), 0);
      @(negedge clk); garbage(); cyc++;
      exp = refMem[(addr + i) % DEPTH];
      if (CHK && exp != (seed + i) % 256) errExp = 1'b1;
      if (i == stallWord)     ns = stallLen;
      else if (stallWord == -1) ns = $urandom_range(0, 2);
      else                    ns = 0;
      for (int s = 0; s <= ns; s++) begin
        checkVal("rd_valid", 32'(bus.rd_valid), 1);
        checkVal("rd_data",  32'(bus.rd_data), exp);
        checkVal("rd_last",  32'(bus.rd_last), (i == len - 1) ? 1 : 0);
        checkVal("rd_hold_en", 32'(bus.ram_en), 0);
        checkVal("rd_err",   32'(bus.err), 32'(errExp));
        bus.rd_ready = (s == ns);
        @(negedge clk); cyc++;
        bus.cmd_valid = 1'($urandom_range(0, 1));
      end
      stalls += ns;
    end
    bus.cmd_valid = 1'b0;
    checkVal("rd_done",   32'({bus.done, bus.ram_en, bus.rd_valid, bus.cmd_ready}), 4'b1001);
    checkVal("rd_cycles", 32'(cyc), 3 * len + stalls);
    checkVal("rd_err_end", 32'(bus.err), 32'(errExp));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal(tag, 32'({bus.cmd_ready, bus.ram_en, bus.ram_wr, bus.ram_addr, bus.rd_valid,
                       bus.rd_last, bus.done, bus.err}), 0);
    checkVal({tag, "_data"}, 32'({bus.ram_din, bus.rd_data}), 0);
  endtask

  initial begin
    int seedA;
    bus.cmd_valid = 1'b0;
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.cmd_seed  = '0;
    bus.rd_ready  = 1'b0;
    errExp = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      ramMem[a] = '0;
      refMem[a] = 0;
    end

    #2 rst = 1'b1;
    #1 checkResetOutputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkVal("ready_after_rst", 32'(bus.cmd_ready), 0);

    // Directed bursts
    doWrite(1, 4, 8'h4B);
    doRead(1, 4, 8'h4B, -2, 0);
    doRead(1, 4, 8'h4B, 2, 5);
    doWrite(6, 4, 8'h20);
    doRead(6, 4, 8'h20, -2, 0);
    doWrite(3, 0, 8'h55);
    @(negedge clk);
    checkVal("done_pulse", 32'({bus.done, bus.ram_en}), 0);
    doRead(0, 0, 8'h00, -2, 0);

    // Reset in the middle of a write: words 0 and 1 have landed, word 2 is on the port
    seedA = 8'hA0;
    issue(1'b1, 2, 6, seedA);
    @(negedge clk);
    @(negedge clk);
    checkVal("mid_addr", 32'(bus.ram_addr), 4);
    refMem[2] = seedA;
    refMem[3] = seedA + 1;
    bus.cmd_valid = 1'b0;
    #2 rst = 1'b1;
    #1 checkResetOutputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    doRead(2, 6, seedA, -2, 0);

    // Readback checker: bad seed, then a good read clears the flag
    doWrite(0, 4, 8'h10);
    doRead(0, 4, 8'h11, -2, 0);
    doRead(0, 4, 8'h10, -2, 0);

    // Randomized bursts, including lengths beyond DEPTH and address wrap
    for (int n = 0; n < 40; n++) begin
      int a = $urandom_range(0, DEPTH - 1);
      int l = $urandom_range(0, 2 * DEPTH - 1);
      int s = $urandom_range(0, 255);
      if ($urandom_range(0, 1) == 1) doWrite(a, l, s);
      else doRead(a, l, ($urandom_range(0, 1) == 1) ? refMem[a] : s, -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ram_burst_ctrl.md
# ram_burst_ctrl

Single-clock burst initiator that drives one port of the team's dual-port RAM: it accepts a burst command over a valid/ready handshake, then either fills a contiguous address range with an incrementing data pattern or reads a range back and streams the words out with backpressure. It sits between a test/control sequencer and a RAM port (en/wr/addr/din/dout), replacing hand-driven port stimulus.

## Interface

- ADDR_W, 3, RAM address width; DEPTH = 2^ADDR_W
- DATA_W, 8, RAM data width
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; reset 0
- cmd_wr  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  start address
- cmd_len  in  ADDR_W+1  word count, 0..2^(ADDR_W+1)-1
- cmd_seed  in  DATA_W  pattern seed; word i = cmd_seed + i, mod 2^DATA_W
- ram_en, ram_wr  out  1 each  RAM port enable / write; reset 0
- ram_addr  out  ADDR_W  RAM address; reset 0
- ram_din  out  DATA_W  RAM write data; reset 0
- ram_dout  in  DATA_W  RAM read data, valid the cycle after a read is issued
- rd_valid, rd_ready  out/in  1  read-data stream handshake; rd_valid reset 0
- rd_data  out  DATA_W  read word, held while rd_valid && !rd_ready; reset 0
- rd_last  out  1  marks final word of burst; reset 0
- done  out  1  one-cycle burst-complete pulse; reset 0
- err  out  1  sticky readback-mismatch flag (see Configuration); reset 0

## Operation

- All outputs registered. FSM states: IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_HOLD.
- IDLE: cmd_ready=1. Command is accepted on an edge with cmd_valid && cmd_ready. The command is latched, and the word index i is cleared to 0.
- cmd_len=0: no RAM access; the FSM stays in IDLE and done=1 in the next cycle.
- WRITE: one word per cycle, with ram_en=1, ram_wr=1, ram_addr=cmd_addr+i, ram_din=cmd_seed+i. After word cmd_len-1 the FSM goes to IDLE.
- RD_ISSUE: ram_en=1, ram_wr=0, ram_addr=cmd_addr+i. The next state is RD_WAIT.
- RD_WAIT: ram_en=0. On the edge at the end of RD_WAIT, ram_dout is captured into rd_data, rd_valid is set, and rd_last is set if i = cmd_len-1. The next state is RD_HOLD.
- RD_HOLD: rd_data and rd_last hold until rd_valid && rd_ready. On that handshake edge, rd_valid drops and i increments. The FSM then goes to RD_ISSUE, or to IDLE after the last word. No RAM access occurs while in RD_HOLD.
- Address arithmetic is mod DEPTH, so addresses wrap past DEPTH-1 to 0. cmd_len > DEPTH is legal: the burst revisits addresses, and later writes overwrite earlier ones.
- done=1 for exactly the first IDLE cycle after a burst. cmd_ready is also 1 in that cycle, so back-to-back commands are allowed.
- cmd_valid while busy is ignored. Command inputs are only sampled at acceptance.
- rst asserted mid-burst immediately forces IDLE-with-reset values. The burst is abandoned and RAM contents written so far are kept.

## Timing

- Write burst of L words: cmd accepted at edge k. ram_en is high in cycles k..k+L-1. done is high in cycle k+L.
- Read latency: 2 cycles from a word's RD_ISSUE to rd_valid.
- Read throughput with rd_ready held high: 1 word per 3 cycles. A burst of L words has done in cycle k+3L.
- ram_en/ram_wr are never high in IDLE, RD_WAIT or RD_HOLD.

## Configuration

- RAM_BURST_CHECK_EN defined:
  - During reads, each captured word is compared against cmd_seed+i.
  - On a mismatch, err is set in the same edge that sets rd_valid.
  - err is sticky until the next command acceptance or rst.
- RAM_BURST_CHECK_EN undefined: err is tied to 0 and no comparator is built.

## Test plan

- Write, cmd_addr=1, cmd_len=4, seed=0x4B -> 4 write cycles at addresses 1..4 with data 4B, 4C, 4D, 4E; done pulses in cycle k+4.
- Read of the same range with rd_ready=1 -> rd_data 4B, 4C, 4D, 4E; rd_last only on 4E; done at k+12; err=0.
- Read with rd_ready held low 5 cycles on word 2 -> rd_data stable, ram_en=0 throughout, no word lost or duplicated.
- Write, addr=6, len=4 -> ram_addr 6, 7, 0, 1. Separately, len=0 -> done next cycle with ram_en never high.
- rst pulsed during word 2 of a write -> all outputs reset asynchronously; a new command is accepted afterwards.
- With RAM_BURST_CHECK_EN: write seed 0x10, then read back with seed 0x11 -> err=1 on the first word and stays 1; a following good read clears err at acceptance and err stays 0.
